instr_fetch: RTL

//  Instruction fetch unit for the SISC core; producer side of the control unit's opcode/mm inputs.
//  On a fetch request from ctrl it reads instruction memory at PC over a req/ack handshake.
//  It latches the word into the IR, advances PC, and presents opcode = IR[31:28] and mm = IR[27:24].
//  It also applies branch PC loads (absolute/relative) and flags memory that never answers.

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch_if.sv | 19 +
 rtl/instr_fetch_wdog.sv | 43 ++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : instr_fetch_pkg
// Brief   : SISC opcode constants, IR field positions, fetch FSM encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 28;
  localparam int IR_MM_MSB = 27;
  localparam int IR_MM_LSB = 24;

  localparam int WDOG_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_fetch_if
// Brief     : Instruction-memory read bus (req/ack handshake).
// Rev       : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ack;
  logic [DATA_W-1:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_wdog.sv
`default_nettype none
// ============================================================================
// Module : fetch_wdog
// Brief  : 8-bit fetch timeout counter with clear/enable and terminal count.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_wdog
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WDOG_W-1:0] count_q;
  logic [WDOG_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count marks the last cycle a request may still wait for ack.
  assign tc = (count_q == WDOG_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : SISC fetch unit: reads IM at PC, loads IR, advances/branches PC.
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               halt,
  input  logic               pc_write,
  input  logic               br_sel,
  input  logic [ADDR_W-1:0]  br_addr,
  instr_fetch_if.master      im,
  output logic [DATA_W-1:0]  ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic               ir_valid,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              wdog_clr;
  logic              wdog_en;
  logic              wdog_tc;

  fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (wdog_clr),
    .en  (wdog_en),
    .tc  (wdog_tc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    im_addr_d   = im_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = 1'b0;
    fetch_err_d = fetch_err_q;
    wdog_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !halt) begin
          state_d   = ST_BUSY;
          im_addr_d = pc_q;
        end
      end
      ST_BUSY: begin
        if (im.im_ack) begin
          ir_d       = im.im_rdata;
          pc_d       = pc_q + ADDR_W'(1);
          ir_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (wdog_tc) begin
          // Abort: hand ctrl a NOOP and skip the unreadable word.
          ir_d        = '0;
          fetch_err_d = 1'b1;
          pc_d        = pc_q + ADDR_W'(1);
          ir_valid_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wdog_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A branch load overrides any increment from a completing fetch.
    if (pc_write) begin
      pc_d = br_sel ? (pc_q + br_addr) : br_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      im_addr_q   <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      im_addr_q   <= im_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // The counter only runs while a request is outstanding.
  assign wdog_clr = (state_q == ST_IDLE);

  assign im.im_req  = (state_q == ST_BUSY);
  assign im.im_addr = im_addr_q;
  assign busy       = (state_q == ST_BUSY);
  assign ir         = ir_q;
  assign opcode     = ir_q[IR_OP_MSB:IR_OP_LSB];
  assign mm         = ir_q[IR_MM_MSB:IR_MM_LSB];
  assign ir_valid   = ir_valid_q;
  assign pc         = pc_q;
  assign fetch_err  = fetch_err_q;

endmodule
`default_nettype wire
